// File: rtl/time_set_ctrl.sv
// Time-setting controller: debounced mode/up/down buttons edit hour/min/sec and commit them to the counter.
// Optional feature macro: TIME_SET_AUTO_REPEAT_EN (hold-to-repeat on up/down while editing).
module time_set_ctrl #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_CYCLES   = 64
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic [5:0] cur_sec,
    input  logic [5:0] cur_min,
    input  logic [4:0] cur_hour,
    output logic       load1,
    output logic       load2,
    output logic       load3,
    output logic [5:0] data1,
    output logic [5:0] data2,
    output logic [5:0] data3,
    output logic       enable,
    output logic [1:0] field
);

    typedef enum logic [2:0] {
        S_RUN      = 3'd0,
        S_EDIT_H   = 3'd1,
        S_EDIT_M   = 3'd2,
        S_EDIT_S   = 3'd3,
        S_COMMIT_H = 3'd4,
        S_COMMIT_M = 3'd5,
        S_COMMIT_S = 3'd6
    } state_t;

    localparam logic [15:0] DB_LAST = 16'(DEBOUNCE_CYCLES - 1);

    function automatic logic [5:0] f_wrap_inc(input logic [5:0] val, input logic [5:0] max);
        f_wrap_inc = (val >= max) ? 6'd0 : val + 6'd1;
    endfunction

    function automatic logic [5:0] f_wrap_dec(input logic [5:0] val, input logic [5:0] max);
        f_wrap_dec = (val == 6'd0) ? max : val - 6'd1;
    endfunction

    state_t      r_state;
    logic [4:0]  r_hour;
    logic [5:0]  r_min;
    logic [5:0]  r_sec;

    // Button index 0 = mode, 1 = up, 2 = down.
    logic [2:0]  w_btn_raw;
    logic [2:0]  r_sync1;
    logic [2:0]  r_sync2;
    logic [2:0]  r_db;
    logic [2:0]  r_press;
    logic [15:0] r_db_cnt [3];

    logic        w_in_edit;
    logic [1:0]  w_rpt;
    logic        w_mode_p;
    logic        w_up_p;
    logic        w_dn_p;
    logic        w_step_up;
    logic        w_step_dn;
    logic [5:0]  w_hour_inc;
    logic [5:0]  w_hour_dec;
    logic [5:0]  w_min_inc;
    logic [5:0]  w_min_dec;
    logic [5:0]  w_sec_inc;
    logic [5:0]  w_sec_dec;

    assign w_btn_raw = {btn_down, btn_up, btn_mode};
    assign w_in_edit = (r_state == S_EDIT_H) || (r_state == S_EDIT_M) || (r_state == S_EDIT_S);

    // Synchronize, debounce and edge-detect all three buttons.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_sync1 <= 3'b000;
            r_sync2 <= 3'b000;
            r_db    <= 3'b000;
            r_press <= 3'b000;
            for (int i = 0; i < 3; i++) begin
                r_db_cnt[i] <= 16'd0;
            end
        end else begin
            r_sync1 <= w_btn_raw;
            r_sync2 <= r_sync1;
            for (int i = 0; i < 3; i++) begin
                r_press[i] <= 1'b0;
                if (r_sync2[i] != r_db[i]) begin
                    if (r_db_cnt[i] >= DB_LAST) begin
                        r_db[i]     <= r_sync2[i];
                        r_db_cnt[i] <= 16'd0;
                        r_press[i]  <= r_sync2[i];
                    end else begin
                        r_db_cnt[i] <= r_db_cnt[i] + 16'd1;
                    end
                end else begin
                    r_db_cnt[i] <= 16'd0;
                end
            end
        end
    end

`ifdef TIME_SET_AUTO_REPEAT_EN
    localparam int              RPT_W      = $clog2(4 * REPEAT_CYCLES + 1);
    localparam logic [RPT_W-1:0] RPT_FIRST  = RPT_W'(4 * REPEAT_CYCLES - 1);
    localparam logic [RPT_W-1:0] RPT_RELOAD = RPT_W'(3 * REPEAT_CYCLES);

    logic [RPT_W-1:0] r_rpt_cnt [2];
    logic [1:0]       r_rpt_pulse;

    // Hold timers for up/down: first step after 4 intervals, then one per interval.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_rpt_pulse <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                r_rpt_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                r_rpt_pulse[i] <= 1'b0;
                if (w_in_edit && r_db[i+1]) begin
                    if (r_rpt_cnt[i] >= RPT_FIRST) begin
                        r_rpt_cnt[i]   <= RPT_RELOAD;
                        r_rpt_pulse[i] <= 1'b1;
                    end else begin
                        r_rpt_cnt[i] <= r_rpt_cnt[i] + 1'b1;
                    end
                end else begin
                    r_rpt_cnt[i] <= '0;
                end
            end
        end
    end

    assign w_rpt = r_rpt_pulse;
`else
    // Repeat disabled: folds to zero for any legal interval.
    assign w_rpt = {2{REPEAT_CYCLES == 0}};
`endif

    assign w_mode_p  = r_press[0];
    assign w_up_p    = r_press[1] | w_rpt[0];
    assign w_dn_p    = r_press[2] | w_rpt[1];
    assign w_step_up = w_up_p & ~w_dn_p;
    assign w_step_dn = w_dn_p & ~w_up_p;

    assign w_hour_inc = f_wrap_inc({1'b0, r_hour}, 6'd23);
    assign w_hour_dec = f_wrap_dec({1'b0, r_hour}, 6'd23);
    assign w_min_inc  = f_wrap_inc(r_min, 6'd59);
    assign w_min_dec  = f_wrap_dec(r_min, 6'd59);
    assign w_sec_inc  = f_wrap_inc(r_sec, 6'd59);
    assign w_sec_dec  = f_wrap_dec(r_sec, 6'd59);

    // Main FSM; outputs are registered alongside each transition so they match the new state.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_RUN;
            r_hour  <= 5'd0;
            r_min   <= 6'd0;
            r_sec   <= 6'd0;
            data1   <= 6'd0;
            data2   <= 6'd0;
            data3   <= 6'd0;
            load1   <= 1'b0;
            load2   <= 1'b0;
            load3   <= 1'b0;
            enable  <= 1'b1;
            field   <= 2'd0;
        end else begin
            data1 <= r_sec;
            data2 <= r_min;
            data3 <= {1'b0, r_hour};
            case (r_state)
                S_RUN: begin
                    if (w_mode_p) begin
                        r_hour  <= cur_hour;
                        r_min   <= cur_min;
                        r_sec   <= cur_sec;
                        r_state <= S_EDIT_H;
                        enable  <= 1'b0;
                        field   <= 2'd1;
                    end
                end
                S_EDIT_H: begin
                    if (w_mode_p) begin
                        r_state <= S_EDIT_M;
                        field   <= 2'd2;
                    end else if (w_step_up) begin
                        r_hour <= w_hour_inc[4:0];
                    end else if (w_step_dn) begin
                        r_hour <= w_hour_dec[4:0];
                    end
                end
                S_EDIT_M: begin
                    if (w_mode_p) begin
                        r_state <= S_EDIT_S;
                        field   <= 2'd3;
                    end else if (w_step_up) begin
                        r_min <= w_min_inc;
                    end else if (w_step_dn) begin
                        r_min <= w_min_dec;
                    end
                end
                S_EDIT_S: begin
                    if (w_mode_p) begin
                        r_state <= S_COMMIT_H;
                        field   <= 2'd0;
                        load3   <= 1'b1;
                    end else if (w_step_up) begin
                        r_sec <= w_sec_inc;
                    end else if (w_step_dn) begin
                        r_sec <= w_sec_dec;
                    end
                end
                S_COMMIT_H: begin
                    r_state <= S_COMMIT_M;
                    load3   <= 1'b0;
                    load2   <= 1'b1;
                end
                S_COMMIT_M: begin
                    r_state <= S_COMMIT_S;
                    load2   <= 1'b0;
                    load1   <= 1'b1;
                end
                S_COMMIT_S: begin
                    r_state <= S_RUN;
                    load1   <= 1'b0;
                    enable  <= 1'b1;
                end
                default: begin
                    r_state <= S_RUN;
                    load1   <= 1'b0;
                    load2   <= 1'b0;
                    load3   <= 1'b0;
                    enable  <= 1'b1;
                    field   <= 2'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed bench for time_set_ctrl: edit entry, wrap, debounce rejection, commit strobes, reset abort.
module tb_time_set_ctrl;

`ifdef TIME_SET_AUTO_REPEAT_EN
    localparam int RPT = 8;
`else
    localparam int RPT = 64;
`endif

    logic       clock = 1'b0;
    logic       reset;
    logic       btn_mode, btn_up, btn_down;
    logic [5:0] cur_sec, cur_min;
    logic [4:0] cur_hour;
    logic       load1, load2, load3;
    logic [5:0] data1, data2, data3;
    logic       enable;
    logic [1:0] field;

    int n_pass  = 0;
    int n_total = 0;

    time_set_ctrl #(.DEBOUNCE_CYCLES(16), .REPEAT_CYCLES(RPT)) dut (
        .clock    (clock),
        .reset    (reset),
        .btn_mode (btn_mode),
        .btn_up   (btn_up),
        .btn_down (btn_down),
        .cur_sec  (cur_sec),
        .cur_min  (cur_min),
        .cur_hour (cur_hour),
        .load1    (load1),
        .load2    (load2),
        .load3    (load3),
        .data1    (data1),
        .data2    (data2),
        .data3    (data3),
        .enable   (enable),
        .field    (field)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic press(input logic m, input logic u, input logic d);
        btn_mode = m; btn_up = u; btn_down = d;
        cycles(22);
        btn_mode = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
        cycles(22);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycles(3);
        reset = 1'b0;
        cycles(1);
    endtask

    int  lat;
    int  l1_cnt;
    bit  seen;

    initial begin
        reset = 1'b1; btn_mode = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
        cur_sec = 6'd0; cur_min = 6'd0; cur_hour = 5'd0;
        cycles(3);
        check_eq("rst_enable", enable, 32'd1);
        check_eq("rst_field", field, 32'd0);
        check_eq("rst_loads", {load3, load2, load1}, 32'd0);
        check_eq("rst_data", {data3, data2, data1}, 32'd0);
        reset = 1'b0;
        cycles(2);

        // Enter edit with live time 12:34:56, mode held 20 cycles.
        cur_hour = 5'd12; cur_min = 6'd34; cur_sec = 6'd56;
        btn_mode = 1'b1;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clock);
            if (lat == 0 && field == 2'd1) lat = i;
        end
        btn_mode = 1'b0;
        check_eq("mode_latency_ok", (lat != 0 && lat <= 20) ? 32'd1 : 32'd0, 32'd1);
        cycles(25);
        check_eq("edit_field_h", field, 32'd1);
        check_eq("edit_enable", enable, 32'd0);
        check_eq("capture_hour", data3, 32'd12);
        check_eq("capture_min", data2, 32'd34);
        check_eq("capture_sec", data1, 32'd56);
        do_reset();
        check_eq("abort_edit_field", field, 32'd0);
        check_eq("abort_edit_enable", enable, 32'd1);

        // Wrap tests from 23:00:00.
        cur_hour = 5'd23; cur_min = 6'd0; cur_sec = 6'd0;
        press(1'b1, 1'b0, 1'b0);
        check_eq("hour_start", data3, 32'd23);
        press(1'b0, 1'b1, 1'b0);
        check_eq("hour_wrap_up", data3, 32'd0);
        press(1'b0, 1'b0, 1'b1);
        check_eq("hour_wrap_down", data3, 32'd23);
        press(1'b1, 1'b0, 1'b0);
        check_eq("field_m", field, 32'd2);
        press(1'b0, 1'b0, 1'b1);
        check_eq("min_wrap_down", data2, 32'd59);
        press(1'b0, 1'b1, 1'b0);
        check_eq("min_wrap_up", data2, 32'd0);

        // Bouncing up button: 5-cycle period for 100 cycles.
        for (int i = 0; i < 20; i++) begin
            btn_up = 1'b1; cycles(2);
            btn_up = 1'b0; cycles(3);
        end
        cycles(25);
        check_eq("bounce_reject", data2, 32'd0);
        press(1'b0, 1'b1, 1'b1);
        check_eq("up_down_same", data2, 32'd0);
        press(1'b1, 1'b1, 1'b0);
        check_eq("mode_prio_field", field, 32'd3);
        check_eq("mode_prio_min", data2, 32'd0);
        check_eq("mode_prio_sec", data1, 32'd0);

        // Edit to 05:07:09 and commit.
        do_reset();
        cur_hour = 5'd4; cur_min = 6'd6; cur_sec = 6'd8;
        press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b1, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b1, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b1, 1'b0);
        check_eq("pre_commit_h", data3, 32'd5);
        check_eq("pre_commit_m", data2, 32'd7);
        check_eq("pre_commit_s", data1, 32'd9);
        btn_mode = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            if (load3 && !seen) begin
                seen = 1'b1;
                check_eq("commit_h_loads", {load3, load2, load1}, 32'd4);
                check_eq("commit_h_data", data3, 32'd5);
                check_eq("commit_h_enable", enable, 32'd0);
                check_eq("commit_h_field", field, 32'd0);
                @(negedge clock);
                check_eq("commit_m_loads", {load3, load2, load1}, 32'd2);
                check_eq("commit_m_data", data2, 32'd7);
                @(negedge clock);
                check_eq("commit_s_loads", {load3, load2, load1}, 32'd1);
                check_eq("commit_s_data", data1, 32'd9);
                @(negedge clock);
                check_eq("post_commit_loads", {load3, load2, load1}, 32'd0);
                check_eq("post_commit_enable", enable, 32'd1);
                check_eq("post_commit_field", field, 32'd0);
            end
        end
        check_eq("commit_seen", {31'd0, seen}, 32'd1);
        btn_mode = 1'b0;
        cycles(25);
        press(1'b0, 1'b1, 1'b0);
        check_eq("run_up_ignored", data3, 32'd5);
        check_eq("run_enable", enable, 32'd1);

        // Reset during COMMIT_M aborts the remaining strobe.
        do_reset();
        cur_hour = 5'd1; cur_min = 6'd2; cur_sec = 6'd3;
        press(1'b1, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        btn_mode = 1'b1;
        seen = 1'b0;
        l1_cnt = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clock);
            if (load1) l1_cnt++;
            if (load2 && !seen) begin
                seen = 1'b1;
                reset = 1'b1;
                btn_mode = 1'b0;
                @(negedge clock);
                if (load1) l1_cnt++;
                check_eq("rst_commit_loads", {load3, load2, load1}, 32'd0);
                check_eq("rst_commit_enable", enable, 32'd1);
                check_eq("rst_commit_field", field, 32'd0);
                check_eq("rst_commit_data", {data3, data2, data1}, 32'd0);
                reset = 1'b0;
            end
        end
        check_eq("rst_commit_seen", {31'd0, seen}, 32'd1);
        check_eq("rst_commit_no_load1", l1_cnt, 32'd0);

`ifdef TIME_SET_AUTO_REPEAT_EN
        // Auto-repeat: debounced up held 100 cycles in EDIT_S from 0.
        do_reset();
        cur_hour = 5'd0; cur_min = 6'd0; cur_sec = 6'd0;
        press(1'b1, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        btn_up = 1'b1;
        cycles(100);
        btn_up = 1'b0;
        cycles(30);
        check_eq("auto_repeat_sec", data1, 32'd10);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/time_set_ctrl.md
TIME_SET_CTRL -- requirements
Module: time_set_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16, is the consecutive synchronized cycles a button level must hold before the debounced level changes (range 2..65535).
REQ-002 Parameter REPEAT_CYCLES, default 64, is the auto-repeat interval in cycles; it is used only with AUTO_REPEAT_EN.
REQ-003 Port clock  input  1  is the single clock; all state updates on its rising edge.
REQ-004 Port reset  input  1  is the reset: synchronous, active-high.
REQ-005 Ports btn_mode, btn_up, btn_down  input  1 each  are raw asynchronous push-buttons, active-high.
REQ-006 Ports cur_sec, cur_min  input  6 each, and cur_hour  input  5, are the live time from the time-of-day counter.
REQ-007 Ports load1, load2, load3  output  1 each  are load strobes to the counter for sec, min and hour respectively.
REQ-008 Ports data1, data2  output  6 each  carry sec and min; data3  output  6  carries {1'b0, hour}.
REQ-009 Port enable  output  1  is the counter run enable.
REQ-010 Port field  output  2  is the edited field: 0 none, 1 hour, 2 min, 3 sec.

Function
REQ-011 Each button passes a 2-flop synchronizer; its debounced level changes only after the synchronized level differs from it for DEBOUNCE_CYCLES consecutive cycles; a press is a 1-cycle pulse on the debounced 0->1 edge.
REQ-012 The FSM states are RUN, EDIT_H, EDIT_M, EDIT_S, COMMIT_H, COMMIT_M, COMMIT_S.
REQ-013 In RUN, a mode press captures cur_hour/cur_min/cur_sec into edit registers and moves to EDIT_H.
REQ-014 A mode press moves EDIT_H->EDIT_M->EDIT_S->COMMIT_H; COMMIT_H->COMMIT_M->COMMIT_S->RUN then advances unconditionally, one state per cycle.
REQ-015 In EDIT_x, an up press increments the selected field and a down press decrements it, with wrap: hour 23<->0, min/sec 59<->0.
REQ-016 Simultaneous up and down presses leave the field unchanged; a mode press in the same cycle as up/down takes priority and the up/down press is discarded.
REQ-017 load3 is high only in COMMIT_H, load2 only in COMMIT_M, and load1 only in COMMIT_S; at most one strobe is high per cycle and each is high for exactly 1 cycle per commit.
REQ-018 data1/data2/data3 are registered copies of the edit registers and are stable throughout COMMIT_*.
REQ-019 enable is 1 in RUN and 0 in every other state; field reflects EDIT_x, and is 0 in RUN and COMMIT_*.
REQ-020 Up/down presses in RUN and COMMIT_* are ignored; mode presses in COMMIT_* are ignored.

Reset
REQ-021 Reset sets: state RUN, enable 1, field 0, load1..3 0, data1..3 0, edit registers 0, synchronizers/debounced levels/debounce counters 0, repeat timers 0.
REQ-022 Reset asserted in any EDIT_x or COMMIT_* state aborts the edit with no further load strobes; the cycle after reset deasserts is RUN.

Configuration
REQ-023 Macro TIME_SET_AUTO_REPEAT_EN: when defined, a debounced up (down) level held in EDIT_x generates an extra increment (decrement) after 4*REPEAT_CYCLES cycles of hold, then one every REPEAT_CYCLES cycles until release; when undefined, only the press edge acts and the repeat logic is absent.

Verification
REQ-024 cur=12:34:56, hold btn_mode 20 cycles -> within DEBOUNCE_CYCLES+4 cycles field=1, enable=0, edit=12:34:56.
REQ-025 EDIT_H at hour 23, one up press -> hour 0; EDIT_M at min 0, one down press -> min 59.
REQ-026 Edit to 05:07:09, press mode until COMMIT_H -> load3 (data3=5), load2 (data2=7), load1 (data1=9) on 3 consecutive cycles, then RUN with enable=1.
REQ-027 btn_up toggling with a 5-cycle period for 100 cycles (DEBOUNCE_CYCLES=16) -> no field change; up+down pressed on the same cycle -> no change.
REQ-028 Reset asserted during COMMIT_M -> no load1 pulse; next cycle state RUN, all outputs at reset values.
REQ-029 With TIME_SET_AUTO_REPEAT_EN and REPEAT_CYCLES=8, hold up 100 cycles after the debounce in EDIT_S from 0 -> sec = 1 + floor((100-32)/8) + 1 = 10.
